// File: rtl/prog_loader.sv
// Boot loader: receives a framed program image over a byte stream, writes it into
// instruction memory word by word and releases the CPU once the checksum matches.
module prog_loader #(
   parameter int         ADDR_W = 8,
   parameter logic [7:0] MAGIC  = 8'hA5
) (
   input  logic        clk_pi,
   input  logic        reset_pi,
   input  logic        clk_en_pi,
   input  logic        rx_valid_pi,
   input  logic [7:0]  rx_data_pi,
   output logic        rx_ready_po,
   input  logic        reload_pi,
   output logic        imem_we_po,
   output logic [15:0] imem_addr_po,
   output logic [15:0] imem_wdata_po,
   output logic        cpu_reset_po,
   output logic        load_done_po,
   output logic        error_po
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
   } state_t;

   localparam int          IDX_W     = ADDR_W + 1;
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [15:0]        len_q, len_d;
   logic [7:0]         csum_q, csum_d;
   logic [7:0]         hi_q, hi_d;
   logic               we_q, we_d;
   logic [15:0]        addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;
   logic               accept;
   logic [15:0]        n_words;

   assign accept = rx_valid_pi && rx_ready_po;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      csum_d  = csum_q;
      hi_d    = hi_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      n_words = {len_q[15:8], rx_data_pi};

      if (reload_pi) begin
         state_d = S_IDLE;
         idx_d   = '0;
         csum_d  = '0;
      end else if (accept) begin
         case (state_q)
            S_IDLE, S_ERROR: begin
               if (rx_data_pi == MAGIC) begin
                  state_d = S_LEN_HI;
                  idx_d   = '0;
                  csum_d  = '0;
               end
            end
            S_LEN_HI: begin
               len_d   = {rx_data_pi, 8'h00};
               csum_d  = csum_q ^ rx_data_pi;
               state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d  = n_words;
               csum_d = csum_q ^ rx_data_pi;
               if (n_words == 16'd0)
                  state_d = S_CHECK;
               else if ({1'b0, n_words} > MAX_WORDS)
                  state_d = S_ERROR;
               else
                  state_d = S_DATA_HI;
            end
            S_DATA_HI: begin
               hi_d    = rx_data_pi;
               csum_d  = csum_q ^ rx_data_pi;
               state_d = S_DATA_LO;
            end
            S_DATA_LO: begin
               csum_d  = csum_q ^ rx_data_pi;
               we_d    = 1'b1;
               addr_d  = 16'(idx_q[ADDR_W-1:0]);
               wdata_d = {hi_q, rx_data_pi};
               idx_d   = idx_q + 1'b1;
               // idx counts words already written, so this was the last one
               if (17'(idx_q) + 17'd1 == {1'b0, len_q})
                  state_d = S_CHECK;
               else
                  state_d = S_DATA_HI;
            end
            S_CHECK: begin
               state_d = (rx_data_pi == csum_q) ? S_DONE : S_ERROR;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_pi or negedge reset_pi) begin
      if (!reset_pi) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         csum_q  <= '0;
         hi_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (clk_en_pi) begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         hi_q    <= hi_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Status flags depend on the state register alone so the CPU reset never glitches.
   assign rx_ready_po   = (state_q != S_DONE);
   assign cpu_reset_po  = (state_q != S_DONE);
   assign load_done_po  = (state_q == S_DONE);
   assign error_po      = (state_q == S_ERROR);
   assign imem_we_po    = we_q;
   assign imem_addr_po  = addr_q;
   assign imem_wdata_po = wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a byte-offset image parser predicts every output
// each cycle, and literal expectations pin the scenario outcomes.
module tb_prog_loader;

   localparam int         ADDR_W = 8;
   localparam logic [7:0] MAGIC  = 8'hA5;

   logic        clk_pi      = 1'b0;
   logic        reset_pi    = 1'b0;
   logic        clk_en_pi   = 1'b1;
   logic        rx_valid_pi = 1'b0;
   logic [7:0]  rx_data_pi  = 8'h00;
   logic        reload_pi   = 1'b0;
   logic        rx_ready_po;
   logic        imem_we_po;
   logic [15:0] imem_addr_po;
   logic [15:0] imem_wdata_po;
   logic        cpu_reset_po;
   logic        load_done_po;
   logic        error_po;

   int n_tests = 0;
   int n_fail  = 0;

   prog_loader #(.ADDR_W(ADDR_W), .MAGIC(MAGIC)) dut (
      .clk_pi        (clk_pi),
      .reset_pi      (reset_pi),
      .clk_en_pi     (clk_en_pi),
      .rx_valid_pi   (rx_valid_pi),
      .rx_data_pi    (rx_data_pi),
      .rx_ready_po   (rx_ready_po),
      .reload_pi     (reload_pi),
      .imem_we_po    (imem_we_po),
      .imem_addr_po  (imem_addr_po),
      .imem_wdata_po (imem_wdata_po),
      .cpu_reset_po  (cpu_reset_po),
      .load_done_po  (load_done_po),
      .error_po      (error_po)
   );

   initial forever #5 clk_pi = ~clk_pi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: position within the current image, in bytes; 0 means hunting for MAGIC.
   int          m_pos   = 0;
   int          m_n     = 0;
   logic        m_done  = 1'b0;
   logic        m_err   = 1'b0;
   logic        m_we    = 1'b0;
   logic [15:0] m_addr  = 16'h0;
   logic [15:0] m_wdata = 16'h0;
   logic [7:0]  m_csum  = 8'h0;
   logic [7:0]  m_prev  = 8'h0;
   logic [7:0]  m_lenhi = 8'h0;

   task model_step();
      logic [7:0] b;
      int k;
      b    = rx_data_pi;
      m_we = 1'b0;
      if (reload_pi) begin
         m_pos  = 0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else if (rx_valid_pi && !m_done) begin
         if (m_pos == 0) begin
            if (b == MAGIC) begin
               m_pos  = 1;
               m_err  = 1'b0;
               m_csum = 8'h0;
            end
         end else if (m_pos == 1) begin
            m_lenhi = b;
            m_csum  = m_csum ^ b;
            m_pos   = 2;
         end else if (m_pos == 2) begin
            m_n    = {m_lenhi, b};
            m_csum = m_csum ^ b;
            if (m_n > (1 << ADDR_W)) begin
               m_err = 1'b1;
               m_pos = 0;
            end else begin
               m_pos = 3;
            end
         end else begin
            k = m_pos - 3;
            if (k < 2 * m_n) begin
               m_csum = m_csum ^ b;
               if (k % 2 == 1) begin
                  m_we    = 1'b1;
                  m_addr  = 16'(k / 2);
                  m_wdata = {m_prev, b};
               end else begin
                  m_prev = b;
               end
               m_pos++;
            end else begin
               if (b == m_csum) m_done = 1'b1;
               else             m_err  = 1'b1;
               m_pos = 0;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk_pi or negedge reset_pi);
      if (!reset_pi) begin
         m_pos = 0; m_done = 1'b0; m_err = 1'b0; m_we = 1'b0;
         m_addr = 16'h0; m_wdata = 16'h0; m_csum = 8'h0;
      end else if (clk_en_pi) begin
         model_step();
      end
   end

   // Per-cycle compare plus capture of writes that commit on the coming enabled edge.
   logic [15:0] mem [256];
   int          wcnt = 0;

   initial forever begin
      @(negedge clk_pi);
      chk("rx_ready",  rx_ready_po,   !m_done);
      chk("cpu_reset", cpu_reset_po,  !m_done);
      chk("load_done", load_done_po,  m_done);
      chk("error",     error_po,      m_err);
      chk("imem_we",   imem_we_po,    m_we);
      chk("imem_addr", imem_addr_po,  m_addr);
      chk("imem_wdata",imem_wdata_po, m_wdata);
      if (reset_pi && clk_en_pi && imem_we_po) begin
         mem[imem_addr_po[7:0]] = imem_wdata_po;
         wcnt++;
      end
   end

   bit en_mode = 1'b0;
   int en_cnt  = 0;
   initial forever begin
      @(posedge clk_pi);
      #1;
      en_cnt++;
      clk_en_pi = en_mode ? (en_cnt % 4 == 0) : 1'b1;
   end

   logic [7:0] seq [$];

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      int guard;
      guard = 0;
      @(negedge clk_pi);
      rx_valid_pi = 1'b1;
      rx_data_pi  = b;
      forever begin
         acc = clk_en_pi && rx_ready_po;
         @(posedge clk_pi);
         if (acc || guard >= 200) break;
         guard++;
         @(negedge clk_pi);
      end
      chk("byte_accept", acc, 1'b1);
   endtask

   task automatic send_seq();
      foreach (seq[i]) send_byte(seq[i]);
   endtask

   task automatic idle(input int n);
      @(negedge clk_pi);
      rx_valid_pi = 1'b0;
      repeat (n) @(negedge clk_pi);
   endtask

   task automatic pulse_reload();
      @(negedge clk_pi);
      rx_valid_pi = 1'b0;
      reload_pi   = 1'b1;
      @(negedge clk_pi);
      reload_pi   = 1'b0;
   endtask

   task automatic good_image();
      seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
   endtask

   initial begin
      int w0;
      logic [7:0] cs;

      repeat (2) @(negedge clk_pi);
      chk("rst_ready", rx_ready_po, 1'b1);
      chk("rst_cpu",   cpu_reset_po, 1'b1);
      chk("rst_we",    imem_we_po, 1'b0);
      reset_pi = 1'b1;
      @(negedge clk_pi);

      // Two-word image
      w0 = wcnt;
      good_image();
      send_seq();
      idle(2);
      chk("t1_writes", wcnt - w0, 2);
      chk("t1_mem0", mem[0], 16'h1234);
      chk("t1_mem1", mem[1], 16'hABCD);
      chk("t1_done", load_done_po, 1'b1);
      chk("t1_cpu",  cpu_reset_po, 1'b0);
      chk("t1_ready", rx_ready_po, 1'b0);

      // Leading garbage, empty image
      pulse_reload();
      w0 = wcnt;
      seq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
      send_seq();
      idle(2);
      chk("t2_writes", wcnt - w0, 0);
      chk("t2_done", load_done_po, 1'b1);

      // Bad checksum, then recovery straight from the error state
      pulse_reload();
      w0 = wcnt;
      good_image();
      seq[7] = 8'h43;
      send_seq();
      idle(2);
      chk("t3_writes", wcnt - w0, 2);
      chk("t3_err", error_po, 1'b1);
      chk("t3_cpu", cpu_reset_po, 1'b1);
      chk("t3_done", load_done_po, 1'b0);
      good_image();
      send_seq();
      idle(2);
      chk("t3_recover", load_done_po, 1'b1);
      chk("t3_err_clr", error_po, 1'b0);

      // N = 257 exceeds the memory
      pulse_reload();
      w0 = wcnt;
      seq = '{8'hA5, 8'h01, 8'h01};
      send_seq();
      idle(2);
      chk("t4_writes", wcnt - w0, 0);
      chk("t4_err", error_po, 1'b1);

      // N = 256 fills the memory exactly
      w0 = wcnt;
      seq = '{8'hA5, 8'h01, 8'h00};
      cs = 8'h01;
      for (int i = 0; i < 256; i++) begin
         seq.push_back(8'(i));
         seq.push_back(~8'(i));
         cs = cs ^ 8'(i) ^ ~8'(i);
      end
      seq.push_back(cs);
      send_seq();
      idle(2);
      chk("t4b_writes", wcnt - w0, 256);
      chk("t4b_mem0", mem[0], 16'h00FF);
      chk("t4b_mem255", mem[255], 16'hFF00);
      chk("t4b_done", load_done_po, 1'b1);

      // Reload coinciding with the final data byte
      pulse_reload();
      seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
      send_seq();
      @(negedge clk_pi);
      w0 = wcnt;
      rx_data_pi = 8'hCD;
      rx_valid_pi = 1'b1;
      reload_pi = 1'b1;
      @(negedge clk_pi);
      reload_pi = 1'b0;
      rx_valid_pi = 1'b0;
      idle(2);
      chk("t5_writes", wcnt - w0, 0);
      chk("t5_ready", rx_ready_po, 1'b1);
      chk("t5_cpu", cpu_reset_po, 1'b1);
      chk("t5_done", load_done_po, 1'b0);
      good_image();
      send_seq();
      idle(2);
      chk("t5_done2", load_done_po, 1'b1);

      // Asynchronous reset just after a write is launched
      pulse_reload();
      seq = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
      send_seq();
      #1;
      chk("t6_we_pre", imem_we_po, 1'b1);
      chk("t6_wdata_pre", imem_wdata_po, 16'h1234);
      reset_pi = 1'b0;
      #1;
      chk("t6_we", imem_we_po, 1'b0);
      chk("t6_addr", imem_addr_po, 16'h0);
      chk("t6_wdata", imem_wdata_po, 16'h0);
      chk("t6_cpu", cpu_reset_po, 1'b1);
      chk("t6_ready", rx_ready_po, 1'b1);
      chk("t6_done", load_done_po, 1'b0);
      chk("t6_err", error_po, 1'b0);
      @(negedge clk_pi);
      reset_pi = 1'b1;
      seq = '{8'hAB, 8'hCD};
      send_seq();
      good_image();
      send_seq();
      idle(2);
      chk("t6_mem0", mem[0], 16'h1234);
      chk("t6_done2", load_done_po, 1'b1);

      // Sparse clock enable with valid held high
      pulse_reload();
      mem[0] = 16'h0;
      mem[1] = 16'h0;
      w0 = wcnt;
      en_mode = 1'b1;
      good_image();
      send_seq();
      repeat (10) @(negedge clk_pi);
      rx_valid_pi = 1'b0;
      en_mode = 1'b0;
      idle(2);
      chk("t7_writes", wcnt - w0, 2);
      chk("t7_mem0", mem[0], 16'h1234);
      chk("t7_mem1", mem[1], 16'hABCD);
      chk("t7_done", load_done_po, 1'b1);
      chk("t7_cpu", cpu_reset_po, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
